// File: rtl/event_readout_sequencer_if.sv
// FIFO write-side bus between the event readout sequencer and the 16x1024 readout FIFO.
interface event_readout_sequencer_if;
    logic [15:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;

    modport master (output fifo_din, output fifo_wr_en, input fifo_full);
    modport slave  (input fifo_din, input fifo_wr_en, output fifo_full);
endinterface

// File: rtl/event_readout_sequencer.sv
// Drift-tube event sequencer: trigger -> capture window -> drain one word per tube plus trailer
// into the readout FIFO under back-pressure -> tube clear pulse -> re-arm.
module event_readout_sequencer #(
    parameter int          N_TUBES       = 32,
    parameter int          WINDOW_CYCLES = 256,
    parameter int          CLR_CYCLES    = 11,
    parameter int          STALL_LIMIT   = 1024,
    parameter logic [15:0] TRAILER_WORD  = 16'hFFFF
) (
    input  logic                     clk100,
    input  logic                     rst_n,
    input  logic                     scin_coin,
    input  logic [8*N_TUBES-1:0]     tube_data,
    event_readout_sequencer_if.master fifo,
    output logic                     capture_en,
    output logic                     tube_clr,
    output logic                     busy,
    output logic                     overflow,
    output logic [15:0]              dropped_cnt
);

    localparam int WIN_W   = $clog2(WINDOW_CYCLES + 1);
    localparam int CLR_W   = $clog2(CLR_CYCLES + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CLR_W-1:0]   CLR_LAST   = CLR_W'(CLR_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);
    localparam logic [4:0]         IDX_LAST   = 5'(N_TUBES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        TRAILER,
        CLEAR
    } state_t;

    state_t              state, state_nx;
    logic [WIN_W-1:0]    win_cnt, win_nx;
    logic [CLR_W-1:0]    clr_cnt, clr_nx;
    logic [STALL_W-1:0]  stall_cnt, stall_nx;
    logic [4:0]          idx, idx_nx;
    logic                overflow_nx;
    logic [15:0]         dropped_nx;
    logic [15:0]         din;
    logic                wr_en;

    // Address byte: chamber nibble (3A/3B vs 4A/4B) then the tube index bits in wiring order.
    function automatic logic [7:0] tube_addr(input logic [4:0] i);
        return {(i[4] ? 4'b0010 : 4'b1100), i[3], i[0], i[1], i[2]};
    endfunction

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            win_cnt     <= '0;
            clr_cnt     <= '0;
            stall_cnt   <= '0;
            idx         <= '0;
            overflow    <= 1'b0;
            dropped_cnt <= '0;
        end else begin
            state       <= state_nx;
            win_cnt     <= win_nx;
            clr_cnt     <= clr_nx;
            stall_cnt   <= stall_nx;
            idx         <= idx_nx;
            overflow    <= overflow_nx;
            dropped_cnt <= dropped_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        win_nx      = win_cnt;
        clr_nx      = clr_cnt;
        stall_nx    = stall_cnt;
        idx_nx      = idx;
        overflow_nx = overflow;
        dropped_nx  = dropped_cnt;
        din         = TRAILER_WORD;
        wr_en       = 1'b0;
        capture_en  = 1'b0;
        tube_clr    = 1'b0;

        if (scin_coin && (state != IDLE) && (dropped_cnt != '1)) begin
            dropped_nx = dropped_cnt + 16'd1;
        end

        unique case (state)
            IDLE: begin
                if (scin_coin) begin
                    state_nx = CAPTURE;
                    win_nx   = '0;
                end
            end

            CAPTURE: begin
                capture_en = 1'b1;
                if (win_cnt == WIN_LAST) begin
                    state_nx = DRAIN;
                    idx_nx   = '0;
                    stall_nx = '0;
                end else begin
                    win_nx = win_cnt + 1'b1;
                end
            end

            DRAIN, TRAILER: begin
                din   = (state == DRAIN) ? {tube_data[{idx, 3'b000} +: 8], tube_addr(idx)}
                                         : TRAILER_WORD;
                wr_en = ~fifo.fifo_full;
                if (!fifo.fifo_full) begin
                    stall_nx = '0;
                    if (state == TRAILER) begin
                        state_nx = CLEAR;
                        clr_nx   = '0;
                    end else if (idx == IDX_LAST) begin
                        state_nx = TRAILER;
                    end else begin
                        idx_nx = idx + 5'd1;
                    end
                end else if (stall_cnt == STALL_LAST) begin
                    // Abort skips the trailer; the clear pulse still runs so the cells re-arm.
                    overflow_nx = 1'b1;
                    state_nx    = CLEAR;
                    clr_nx      = '0;
                    stall_nx    = '0;
                end else begin
                    stall_nx = stall_cnt + 1'b1;
                end
            end

            CLEAR: begin
                tube_clr = 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state_nx = IDLE;
                end else begin
                    clr_nx = clr_cnt + 1'b1;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    assign busy            = (state != IDLE);
    assign fifo.fifo_din   = din;
    assign fifo.fifo_wr_en = wr_en;

endmodule

// File: tb/tb_event_readout_sequencer.sv
// Directed bench for event_readout_sequencer: scoreboarded FIFO words plus per-event timing counts.
module tb_event_readout_sequencer;

    localparam int N = 32;

    logic            clk100 = 1'b0;
    logic            rst_n;
    logic            scin_coin;
    logic [8*N-1:0]  tube_data;
    logic            capture_en;
    logic            tube_clr;
    logic            busy;
    logic            overflow;
    logic [15:0]     dropped_cnt;

    event_readout_sequencer_if bus();

    event_readout_sequencer #(
        .N_TUBES      (N),
        .WINDOW_CYCLES(256),
        .CLR_CYCLES   (11),
        .STALL_LIMIT  (1024),
        .TRAILER_WORD (16'hFFFF)
    ) dut (
        .clk100     (clk100),
        .rst_n      (rst_n),
        .scin_coin  (scin_coin),
        .tube_data  (tube_data),
        .fifo       (bus),
        .capture_en (capture_en),
        .tube_clr   (tube_clr),
        .busy       (busy),
        .overflow   (overflow),
        .dropped_cnt(dropped_cnt)
    );

    always #5 clk100 = ~clk100;

    int total = 0;
    int bad   = 0;

    logic [15:0] sb[$];
    logic [15:0] wlog[$];
    logic [7:0]  tdat[N];
    int          coin_at[$];

    int cyc_no, wr_cnt, cap_cnt, clr_cnt, busy_cnt;
    int first_cap, first_clr, first_wr, last_wr, last_busy;

    function automatic logic [7:0] model_addr(input int i);
        logic [3:0] ch;
        ch = (i < 16) ? 4'hC : 4'h2;
        return {ch, 1'(i >> 3), 1'(i), 1'(i >> 1), 1'(i >> 2)};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_data(input bit rnd);
        for (int i = 0; i < N; i++) begin
            tdat[i] = rnd ? 8'($urandom) : 8'(i + 1);
            tube_data[8*i +: 8] = tdat[i];
        end
    endtask

    task automatic clear_stats();
        wr_cnt = 0; cap_cnt = 0; clr_cnt = 0; busy_cnt = 0;
        first_cap = -1; first_clr = -1; first_wr = -1; last_wr = -1; last_busy = -1;
        wlog.delete();
    endtask

    // Called at a falling edge: observe the cycle 1 ns later, then wait for the next falling edge.
    task automatic sample();
        #1;
        if (bus.fifo_full) chk("wr_while_full", int'(bus.fifo_wr_en), 0);
        if (bus.fifo_wr_en) begin
            wr_cnt++;
            wlog.push_back(bus.fifo_din);
            if (first_wr < 0) first_wr = cyc_no;
            last_wr = cyc_no;
            chk("sb_word_pending", int'(sb.size() > 0), 1);
            if (sb.size() > 0) chk("fifo_din", int'(bus.fifo_din), int'(sb.pop_front()));
        end
        if (capture_en) begin
            cap_cnt++;
            if (first_cap < 0) first_cap = cyc_no;
        end
        if (tube_clr) begin
            clr_cnt++;
            if (first_clr < 0) first_clr = cyc_no;
        end
        if (busy) begin
            busy_cnt++;
            last_busy = cyc_no;
        end
        @(negedge clk100);
    endtask

    task automatic run_event(input int ncyc, input int full_lo, input int full_hi, input bit push);
        clear_stats();
        if (push) begin
            for (int i = 0; i < N; i++) sb.push_back({tdat[i], model_addr(i)});
            sb.push_back(16'hFFFF);
        end
        cyc_no       = 0;
        scin_coin    = 1'b1;
        bus.fifo_full = 1'b0;
        sample();
        for (int n = 1; n <= ncyc; n++) begin
            cyc_no    = n;
            scin_coin = 1'b0;
            foreach (coin_at[j]) if (coin_at[j] == n) scin_coin = 1'b1;
            bus.fifo_full = (n >= full_lo) && (n <= full_hi);
            sample();
        end
        scin_coin     = 1'b0;
        bus.fifo_full = 1'b0;
    endtask

    initial begin
        bit hit;
        rst_n         = 1'b0;
        scin_coin     = 1'b0;
        bus.fifo_full = 1'b0;
        load_data(1'b0);
        repeat (3) @(negedge clk100);
        #1;
        chk("rst_wr_en",    int'(bus.fifo_wr_en), 0);
        chk("rst_din",      int'(bus.fifo_din), 16'hFFFF);
        chk("rst_busy",     int'(busy), 0);
        chk("rst_capture",  int'(capture_en), 0);
        chk("rst_clr",      int'(tube_clr), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_dropped",  int'(dropped_cnt), 0);
        @(negedge clk100);
        rst_n = 1'b1;
        @(negedge clk100);

        // Nominal event, tube i carries i+1
        run_event(310, 0, -1, 1'b1);
        chk("t1_cap_cnt",   cap_cnt, 256);
        chk("t1_first_cap", first_cap, 1);
        chk("t1_wr_cnt",    wr_cnt, 33);
        chk("t1_first_wr",  first_wr, 257);
        chk("t1_last_wr",   last_wr, 289);
        chk("t1_clr_cnt",   clr_cnt, 11);
        chk("t1_first_clr", first_clr, 290);
        chk("t1_busy_cnt",  busy_cnt, 300);
        chk("t1_last_busy", last_busy, 300);
        chk("t1_sb_empty",  int'(sb.size()), 0);
        chk("t1_log_size",  int'(wlog.size()), 33);
        if (wlog.size() == 33) begin
            chk("t1_word0",  int'(wlog[0]),  16'h01C0);
            chk("t1_word1",  int'(wlog[1]),  16'h02C4);
            chk("t1_word8",  int'(wlog[8]),  16'h09C8);
            chk("t1_word16", int'(wlog[16]), 16'h1120);
            chk("t1_word31", int'(wlog[31]), 16'h202F);
            chk("t1_trailer", int'(wlog[32]), 16'hFFFF);
        end

        // Back-pressure for 5 cycles while idx=3 is presented
        load_data(1'b1);
        run_event(320, 260, 264, 1'b1);
        chk("t2_wr_cnt",   wr_cnt, 33);
        chk("t2_first_wr", first_wr, 257);
        chk("t2_last_wr",  last_wr, 294);
        chk("t2_busy_cnt", busy_cnt, 305);
        chk("t2_sb_empty", int'(sb.size()), 0);

        // Triggers while busy, including the last CLEAR cycle
        coin_at = '{10, 50, 100, 300};
        load_data(1'b1);
        run_event(310, 0, -1, 1'b1);
        coin_at.delete();
        chk("t4_dropped",   int'(dropped_cnt), 4);
        chk("t4_busy_cnt",  busy_cnt, 300);
        chk("t4_wr_cnt",    wr_cnt, 33);
        chk("t4_sb_empty",  int'(sb.size()), 0);

        // FIFO full from DRAIN entry until the stall limit
        run_event(1300, 257, 1280, 1'b0);
        chk("t3_wr_cnt",    wr_cnt, 0);
        chk("t3_overflow",  int'(overflow), 1);
        chk("t3_clr_cnt",   clr_cnt, 11);
        chk("t3_first_clr", first_clr, 1281);
        chk("t3_busy_cnt",  busy_cnt, 1291);
        load_data(1'b1);
        run_event(310, 0, -1, 1'b1);
        chk("t3b_wr_cnt",   wr_cnt, 33);
        chk("t3b_overflow", int'(overflow), 1);
        chk("t3b_sb_empty", int'(sb.size()), 0);
        chk("t3b_dropped",  int'(dropped_cnt), 4);

        // Asynchronous reset while idx=10 is on the bus
        load_data(1'b1);
        run_event(266, 0, -1, 1'b1);
        chk("t5_wr_before", wr_cnt, 10);
        #1;
        chk("t5_pre_wr_en", int'(bus.fifo_wr_en), 1);
        if (sb.size() > 0) chk("t5_pre_din", int'(bus.fifo_din), int'(sb[0]));
        rst_n = 1'b0;
        #1;
        chk("t5_wr_en",    int'(bus.fifo_wr_en), 0);
        chk("t5_busy",     int'(busy), 0);
        chk("t5_din",      int'(bus.fifo_din), 16'hFFFF);
        chk("t5_overflow", int'(overflow), 0);
        chk("t5_dropped",  int'(dropped_cnt), 0);
        sb.delete();
        @(negedge clk100);
        rst_n = 1'b1;
        @(negedge clk100);
        load_data(1'b1);
        run_event(310, 0, -1, 1'b1);
        chk("t5b_cap_cnt",  cap_cnt, 256);
        chk("t5b_first_wr", first_wr, 257);
        chk("t5b_wr_cnt",   wr_cnt, 33);
        chk("t5b_busy_cnt", busy_cnt, 300);
        chk("t5b_sb_empty", int'(sb.size()), 0);

        // Saturation: coincidence held high through back-to-back stalled events
        clear_stats();
        scin_coin     = 1'b1;
        bus.fifo_full = 1'b1;
        hit           = 1'b0;
        for (int n = 0; n < 70000 && !hit; n++) begin
            sample();
            if (dropped_cnt == 16'hFFFE) hit = 1'b1;
        end
        chk("sat_reach_fffe", int'(hit), 1);
        repeat (2000) sample();
        chk("sat_dropped", int'(dropped_cnt), 16'hFFFF);
        chk("sat_wr_cnt",  wr_cnt, 0);
        scin_coin     = 1'b0;
        bus.fifo_full = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
